mont_operand_sender: RTL

- Transmit side of the core's 64-bit operand bus: latches two 1024-bit operands (x, y), pulses the Montgomery core's reset, then streams x followed by y one word per clock.
- Supervises the core's fault-detection flag and re-sends the operands on a detected fault, up to a bounded retry count.
- Sits between the host/controller and the protected Montgomery multiplier core.

---
 rtl/mont_operand_sender_pkg.sv | 23 ++
 rtl/mont_operand_sender_word_serializer.sv | 70 +++++++
 rtl/mont_operand_sender.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mont_operand_sender_pkg.sv
// Shared definitions for the Montgomery operand sender: default operand
// geometry, the sender FSM state encoding and the core fault-flag polarity.
package mont_operand_sender_pkg;

    localparam int INPUT_SIZE_DEF = 1024;
    localparam int WORD_SIZE_DEF  = 64;
    localparam int NUM_WORDS_DEF  = INPUT_SIZE_DEF / WORD_SIZE_DEF;

    // Word counter covers x and y back to back (2*NUM_WORDS words).
    localparam int WORD_CNT_W = 6;

    // Level of core_flag that marks a detected fault.
    localparam logic FAULT_FLAG = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        SEND,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mont_operand_sender_word_serializer.sv
// Holds the latched x/y operand pair and walks it one word per cycle:
// x least-significant word first, then y in the same order. The selected
// word is registered so the bus is driven straight from a flop.
module mont_operand_sender_word_serializer
    import mont_operand_sender_pkg::*;
#(
    parameter int INPUT_SIZE = INPUT_SIZE_DEF,
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int NUM_WORDS  = NUM_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [INPUT_SIZE-1:0] x_in,
    input  logic [INPUT_SIZE-1:0] y_in,
    input  logic                  first,
    input  logic                  advance,
    input  logic                  clear,
    output logic [WORD_SIZE-1:0]  word,
    output logic                  last
);

    localparam int BIT_W = $clog2(2 * INPUT_SIZE);

    logic [2*INPUT_SIZE-1:0] xy_q;
    logic [WORD_CNT_W-1:0]   cnt;
    logic [WORD_CNT_W-1:0]   sel_idx;
    logic [BIT_W-1:0]        bit_base;

    assign last = (cnt == WORD_CNT_W'(2 * NUM_WORDS - 1));

    // Index of the word to present after the next edge.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_idx = cnt;
        if (first) begin
            sel_idx = '0;
        end else if (advance) begin
            sel_idx = last ? '0 : cnt + 1'b1;
        end
        bit_base = BIT_W'(int'(sel_idx) * WORD_SIZE);
    end

    // Operand storage: captured on an accepted start, held across retries.
    always_ff @(posedge clk) begin
        // NOTE: wide data storage is deliberately left out of reset; it is
        // always written before it is read, and resetting it costs fan-out.
        if (load) begin
            xy_q <= {y_in, x_in};
        end
    end

    // Word counter and registered output word.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            cnt  <= '0;
            word <= '0;
        end else if (clear) begin
            cnt  <= '0;
            word <= '0;
        end else if (first || advance) begin
            cnt  <= sel_idx;
            word <= xy_q[bit_base +: WORD_SIZE];
        end
    end

endmodule

// File: rtl/mont_operand_sender.sv
// Transmit side of the Montgomery core operand bus. Latches x and y, pulses
// the core reset, streams x then y one word per clock, then supervises the
// core's fault flag and re-sends on a detected fault up to MAX_RETRY times.
module mont_operand_sender
    import mont_operand_sender_pkg::*;
#(
    parameter int INPUT_SIZE      = INPUT_SIZE_DEF,
    parameter int WORD_SIZE       = WORD_SIZE_DEF,
    parameter int CORE_RST_CYCLES = 2,
    parameter int MAX_RETRY       = 3,
    parameter int WAIT_TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [INPUT_SIZE-1:0] x_in,
    input  logic [INPUT_SIZE-1:0] y_in,
    output logic [WORD_SIZE-1:0]  bus,
    output logic                  bus_valid,
    output logic                  core_reset,
    input  logic                  core_done,
    input  logic                  core_flag,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [1:0]            retry_count
);

    localparam int NUM_WORDS = INPUT_SIZE / WORD_SIZE;
    localparam int RST_W     = $clog2(CORE_RST_CYCLES + 1);
    localparam int TO_W      = $clog2(WAIT_TIMEOUT + 1);

    state_t           state;
    logic [RST_W-1:0] rst_cnt;
    logic [TO_W-1:0]  wait_cnt;

    logic ser_load;
    logic ser_first;
    logic ser_advance;
    logic ser_clear;
    logic ser_last;
    logic rst_last;

    assign rst_last = (rst_cnt == RST_W'(CORE_RST_CYCLES - 1));

    // Serializer control decoded from the current state.
    always_comb begin
        ser_load    = (state == IDLE) && start;
        ser_first   = (state == CORE_RST) && rst_last;
        ser_advance = (state == SEND) && !ser_last;
        ser_clear   = (state == SEND) && ser_last;
    end

    mont_operand_sender_word_serializer #(
        .INPUT_SIZE (INPUT_SIZE),
        .WORD_SIZE  (WORD_SIZE),
        .NUM_WORDS  (NUM_WORDS)
    ) u_serializer (
        .clk     (clk),
        .reset   (reset),
        .load    (ser_load),
        .x_in    (x_in),
        .y_in    (y_in),
        .first   (ser_first),
        .advance (ser_advance),
        .clear   (ser_clear),
        .word    (bus),
        .last    (ser_last)
    );

    // Sender FSM with retry and timeout supervision; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            core_reset  <= 1'b1;
            bus_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            retry_count <= '0;
            rst_cnt     <= '0;
            wait_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CORE_RST;
                        busy        <= 1'b1;
                        core_reset  <= 1'b1;
                        retry_count <= '0;
                        fault       <= 1'b0;
                        rst_cnt     <= '0;
                    end
                end
                CORE_RST: begin
                    if (rst_last) begin
                        state      <= SEND;
                        core_reset <= 1'b0;
                        bus_valid  <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (ser_last) begin
                        state     <= WAIT;
                        bus_valid <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        if (core_flag != FAULT_FLAG) begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b0;
                        end else if (retry_count < 2'(MAX_RETRY)) begin
                            state       <= CORE_RST;
                            core_reset  <= 1'b1;
                            rst_cnt     <= '0;
                            retry_count <= retry_count + 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end
                    end else if (wait_cnt == TO_W'(WAIT_TIMEOUT - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    core_reset <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
